// File: rtl/id_ex_stage_skid.sv
// ID/EX pipeline register with a valid/ready handshake, a two-entry skid buffer,
// synchronous flush for branch/jump bubbles and a saturating back-pressure counter.
module id_ex_stage_skid #(
  parameter int CTRL_W      = 9,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [DATA_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]      read1_in,
  input  logic [DATA_W-1:0]      read2_in,
  input  logic [DATA_W-1:0]      imm_in,
  input  logic [REG_W-1:0]       instr2_in,
  input  logic [REG_W-1:0]       instr1_in,
  input  logic [REG_W-1:0]       rs_in,
  input  logic [REG_W-1:0]       rt_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [DATA_W-1:0]      pc_out,
  output logic [DATA_W-1:0]      read1_out,
  output logic [DATA_W-1:0]      read2_out,
  output logic [DATA_W-1:0]      imm_out,
  output logic [REG_W-1:0]       instr2_out,
  output logic [REG_W-1:0]       instr1_out,
  output logic [REG_W-1:0]       rs_out,
  output logic [REG_W-1:0]       rt_out,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  instr2;
    logic [REG_W-1:0]  instr1;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
  } payload_t;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  payload_t                 r_m;
  payload_t                 r_s;
  logic                     r_m_v;
  logic                     r_s_v;
  logic [STALL_CNT_W-1:0]   r_stall_cnt;

  payload_t                 w_in;
  logic                     w_accept;
  logic                     w_m_free;

  assign w_in = '{
    ctrl:   ctrl_in,
    pc:     pc_in,
    read1:  read1_in,
    read2:  read2_in,
    imm:    imm_in,
    instr2: instr2_in,
    instr1: instr1_in,
    rs:     rs_in,
    rt:     rt_in
  };

  // Ready depends only on the skid flag, so EX back-pressure never reaches ID combinationally.
  assign in_ready = !r_s_v;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_m_free = !r_m_v || out_ready;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: payload registers are reset too, so every output reads 0 right after reset.
      r_m   <= '0;
      r_s   <= '0;
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
    end else if (flush) begin
      // Only the valid bits are dropped; ctrl_out gating turns the stale payload into a bubble.
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
    end else if (w_m_free) begin
      if (r_s_v) begin
        r_m   <= r_s;
        r_m_v <= 1'b1;
        r_s_v <= 1'b0;
      end else if (w_accept) begin
        r_m   <= w_in;
        r_m_v <= 1'b1;
      end else begin
        r_m_v <= 1'b0;
      end
    end else if (w_accept) begin
      r_s   <= w_in;
      r_s_v <= 1'b1;
    end
  end

  // Counts every edge on which EX refuses a valid entry; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_m_v && !out_ready && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid   = r_m_v;
  assign ctrl_out    = r_m.ctrl & {CTRL_W{r_m_v}};
  assign pc_out      = r_m.pc;
  assign read1_out   = r_m.read1;
  assign read2_out   = r_m.read2;
  assign imm_out     = r_m.imm;
  assign instr2_out  = r_m.instr2;
  assign instr1_out  = r_m.instr1;
  assign rs_out      = r_m.rs;
  assign rt_out      = r_m.rt;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_skid.sv
// Directed bench for id_ex_stage_skid: reset, streaming, skid back-pressure, flush,
// counter saturation (second instance with a 4-bit counter) and mid-stream reset.
module tb_id_ex_stage_skid;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] pc_in, read1_in, read2_in, imm_in;
  logic [REG_W-1:0]  instr2_in, instr1_in, rs_in, rt_in;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] pc_out, read1_out, read2_out, imm_out;
  logic [REG_W-1:0]  instr2_out, instr1_out, rs_out, rt_out;
  logic [15:0]       stall_count;

  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_ctrl_out;
  logic [DATA_W-1:0] s_pc_out, s_read1_out, s_read2_out, s_imm_out;
  logic [REG_W-1:0]  s_instr2_out, s_instr1_out, s_rs_out, s_rt_out;
  logic [3:0]        s_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .read1_in(read1_in), .read2_in(read2_in),
    .imm_in(imm_in), .instr2_in(instr2_in), .instr1_in(instr1_in), .rs_in(rs_in),
    .rt_in(rt_in), .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .pc_out(pc_out), .read1_out(read1_out), .read2_out(read2_out), .imm_out(imm_out),
    .instr2_out(instr2_out), .instr1_out(instr1_out), .rs_out(rs_out), .rt_out(rt_out),
    .stall_count(stall_count)
  );

  id_ex_stage_skid #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .read1_in(read1_in), .read2_in(read2_in),
    .imm_in(imm_in), .instr2_in(instr2_in), .instr1_in(instr1_in), .rs_in(rs_in),
    .rt_in(rt_in), .out_valid(s_out_valid), .out_ready(out_ready), .ctrl_out(s_ctrl_out),
    .pc_out(s_pc_out), .read1_out(s_read1_out), .read2_out(s_read2_out),
    .imm_out(s_imm_out), .instr2_out(s_instr2_out), .instr1_out(s_instr1_out),
    .rs_out(s_rs_out), .rt_out(s_rt_out), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one entry; the other payload fields are derived from pc so they are checkable.
  task automatic drive(input logic v, input logic [DATA_W-1:0] pc, input logic [CTRL_W-1:0] ctrl);
    in_valid  = v;
    pc_in     = pc;
    ctrl_in   = ctrl;
    read1_in  = pc + 32'h1000;
    read2_in  = pc + 32'h2000;
    imm_in    = ~pc;
    instr2_in = pc[6:2];
    instr1_in = pc[6:2] + 5'd1;
    rs_in     = pc[6:2] + 5'd2;
    rt_in     = pc[6:2] + 5'd3;
  endtask

  task automatic check_post_reset(input string tag);
    check({tag, ".out_valid"},   64'(out_valid),     64'd0);
    check({tag, ".in_ready"},    64'(in_ready),      64'd1);
    check({tag, ".ctrl_out"},    64'(ctrl_out),      64'd0);
    check({tag, ".pc_out"},      64'(pc_out),        64'd0);
    check({tag, ".read1_out"},   64'(read1_out),     64'd0);
    check({tag, ".rt_out"},      64'(rt_out),        64'd0);
    check({tag, ".stall_count"}, 64'(stall_count),   64'd0);
    check({tag, ".sat_stall"},   64'(s_stall_count), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 9'h0);
    step(); step();
    reset = 1'b0;
    check_post_reset("reset");

    // Streaming: each entry appears one edge after it is presented.
    out_ready = 1'b1;
    drive(1'b1, 32'd4, 9'h1FF);  step();
    check("stream0.pc", 64'(pc_out), 64'd4);
    check("stream0.ctrl", 64'(ctrl_out), 64'h1FF);
    check("stream0.valid", 64'(out_valid), 64'd1);
    drive(1'b1, 32'd8, 9'h1FF);  step();
    check("stream1.pc", 64'(pc_out), 64'd8);
    check("stream1.read1", 64'(read1_out), 64'h1008);
    drive(1'b1, 32'd12, 9'h1FF); step();
    check("stream2.pc", 64'(pc_out), 64'd12);
    check("stream2.imm", 64'(imm_out), 64'hFFFF_FFF3);
    check("stream2.rs", 64'(rs_out), 64'd5);
    drive(1'b0, 32'd16, 9'h1FF); step();
    check("bubble.valid", 64'(out_valid), 64'd0);
    check("bubble.ctrl", 64'(ctrl_out), 64'd0);
    check("bubble.pc_held", 64'(pc_out), 64'd12);
    check("stream.stall", 64'(stall_count), 64'd0);

    // Back-pressure into the skid entry.
    drive(1'b1, 32'h10, 9'h0A5); step();
    check("bp.fill_m", 64'(pc_out), 64'h10);
    out_ready = 1'b0;
    drive(1'b1, 32'h14, 9'h05A); step();
    check("bp.hold_m", 64'(pc_out), 64'h10);
    check("bp.in_ready0", 64'(in_ready), 64'd0);
    check("bp.stall1", 64'(stall_count), 64'd1);
    drive(1'b1, 32'h18, 9'h133); step();
    check("bp.still_m", 64'(pc_out), 64'h10);
    check("bp.ctrl_m", 64'(ctrl_out), 64'h0A5);
    step();
    check("bp.stall3", 64'(stall_count), 64'd3);
    out_ready = 1'b1; step();
    check("bp.drain1.pc", 64'(pc_out), 64'h14);
    check("bp.drain1.ctrl", 64'(ctrl_out), 64'h05A);
    check("bp.drain1.in_ready", 64'(in_ready), 64'd1);
    check("bp.drain1.instr1", 64'(instr1_out), 64'd6);
    step();
    check("bp.drain2.pc", 64'(pc_out), 64'h18);
    check("bp.drain2.ctrl", 64'(ctrl_out), 64'h133);
    check("bp.drain2.valid", 64'(out_valid), 64'd1);
    drive(1'b0, 32'h0, 9'h0); step();
    check("bp.empty", 64'(out_valid), 64'd0);
    check("bp.stall_final", 64'(stall_count), 64'd3);

    // Flush with M and S valid, coincident with out_ready.
    drive(1'b1, 32'h20, 9'h0F0); step();
    out_ready = 1'b0;
    drive(1'b1, 32'h24, 9'h00F); step();
    check("fl.s_full", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h28, 9'h1AA); step();
    flush = 1'b0;
    check("fl.valid", 64'(out_valid), 64'd0);
    check("fl.ctrl", 64'(ctrl_out), 64'd0);
    check("fl.in_ready", 64'(in_ready), 64'd1);
    check("fl.pc_kept", 64'(pc_out), 64'h20);
    drive(1'b0, 32'h0, 9'h0); step();
    check("fl.no_revive", 64'(out_valid), 64'd0);
    check("fl.stall", 64'(stall_count), 64'd4);
    drive(1'b1, 32'h2C, 9'h055); step();
    check("fl.next.pc", 64'(pc_out), 64'h2C);
    check("fl.next.ctrl", 64'(ctrl_out), 64'h055);
    drive(1'b0, 32'h0, 9'h0); step();

    // Saturation: 20 stalled edges; the 4-bit counter stops at 15.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 32'h30, 9'h011); step();
    drive(1'b0, 32'h0, 9'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat.wide", 64'(stall_count), 64'd20);
    check("sat.narrow", 64'(s_stall_count), 64'd15);
    check("sat.m_held", 64'(s_pc_out), 64'h30);

    // Reset mid-stream with M and S both valid.
    drive(1'b1, 32'h40, 9'h1C3); step();
    check("rst.s_full", 64'(in_ready), 64'd0);
    reset = 1'b1; drive(1'b0, 32'h0, 9'h0); step();
    reset = 1'b0;
    check_post_reset("rst_mid");
    step();
    check("rst.idle_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_skid.md
Name: id_ex_stage_skid

Overview:
- Parametrised successor of the ID/EX pipeline register.
- Carries control bits, PC+4, both register-file read values, sign-extended immediate, the two destination-register candidates, and rs/rt from decode to execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so EX back-pressure does not need a combinational ready path into ID.
- Adds a synchronous flush for bubble insertion on branch/jump, and a saturating back-pressure cycle counter for performance debug.

Parameters:
- CTRL_W, 9, width of the control bundle.
- DATA_W, 32, width of PC, read1, read2 and immediate.
- REG_W, 5, width of register specifiers.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all held and incoming entries.
- in_valid  in  1  ID presents a valid entry.
- in_ready  out  1  stage can accept this cycle.
- ctrl_in  in  CTRL_W  control bits.
- pc_in  in  DATA_W  new PC (PC+4).
- read1_in  in  DATA_W  register-file port 1 value.
- read2_in  in  DATA_W  register-file port 2 value.
- imm_in  in  DATA_W  sign-extended immediate.
- instr2_in  in  REG_W  rd candidate (instr[15:11]).
- instr1_in  in  REG_W  rt candidate (instr[20:16]).
- rs_in  in  REG_W  source register rs.
- rt_in  in  REG_W  source register rt.
- out_valid  out  1  EX-side entry valid.
- out_ready  in  1  EX consumes this cycle.
- ctrl_out  out  CTRL_W  control bits; forced to 0 when out_valid=0.
- pc_out  out  DATA_W  registered copy of pc_in.
- read1_out  out  DATA_W  registered copy of read1_in.
- read2_out  out  DATA_W  registered copy of read2_in.
- imm_out  out  DATA_W  registered copy of imm_in.
- instr2_out  out  REG_W  registered copy of instr2_in.
- instr1_out  out  REG_W  registered copy of instr1_in.
- rs_out  out  REG_W  registered copy of rs_in.
- rt_out  out  REG_W  registered copy of rt_in.
- stall_count  out  STALL_CNT_W  cycles with out_valid && !out_ready.

Behaviour:
- Storage:
  - Main entry M drives all *_out ports.
  - Skid entry S holds one overflow entry.
  - Each has a valid bit (m_v, s_v); out_valid = m_v.
- in_ready = !s_v. It is a registered term only, with no combinational path from out_ready.
- accept = in_valid && in_ready && !flush.
- Next-state, priority order:
  1. reset, then flush: m_v<=0, s_v<=0, stall_count unchanged by flush.
  2. If !m_v or out_ready (M drains or is empty):
     - If s_v: M<=S, s_v<=0; if accept in the same cycle, impossible since in_ready=0.
     - Else if accept: M<=input, m_v<=1.
     - Else: m_v<=0.
  3. Else (M held): if accept, S<=input, s_v<=1.
- Latency: input to output is exactly 1 cycle when not back-pressured.
- Throughput: 1 entry per cycle with out_ready held at 1.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- ctrl_out = ctrl register AND {CTRL_W{m_v}}. A bubble therefore never asserts RegWrite/MemWrite in EX.
- Data and specifier outputs keep their last value while m_v=0.
- Reset values:
  - m_v=0, s_v=0.
  - All M and S data fields = 0.
  - stall_count = 0.
  - Hence out_valid=0, in_ready=1, ctrl_out=0 and all *_out = 0 after reset.
- Flush does not zero data fields. It only clears valid bits; ctrl_out reads 0 through gating.
- stall_count:
  - +1 on each edge where m_v && !out_ready && !reset.
  - Saturates at 2^STALL_CNT_W-1.
  - Cleared only by reset.
- Simultaneous flush and out_ready: flush wins; the M entry counts as discarded, not consumed.
- Reset mid-stream: one edge clears everything; in_ready=1 on the following cycle.

Test Plan:
- Reset, then check: out_valid=0, in_ready=1, ctrl_out=0, pc_out=0, stall_count=0.
- Streaming: out_ready=1, send pc_in=4,8,12 on consecutive cycles with ctrl_in=9'h1FF. pc_out=4,8,12 appears on consecutive cycles, each one cycle after input, with ctrl_out=9'h1FF.
- Back-pressure and skid:
  - Fill M with pc=0x10 and drop out_ready.
  - Send pc=0x14 → S captured and in_ready=0 next cycle; pc=0x18 held at input is not accepted.
  - Raise out_ready → outputs 0x10, 0x14, 0x18 in order with no gaps.
  - stall_count equals the number of stalled cycles.
- Flush: with M and S both valid, pulse flush together with out_ready=1. Next cycle out_valid=0, ctrl_out=0 and in_ready=1; the old entries never reappear.
- Saturation: STALL_CNT_W=4, hold out_ready=0 with M valid for 20 cycles → stall_count=15.
- Reset while M and S are valid and out_ready=0 → the next cycle matches the post-reset state from the first scenario.
